// File: rtl/fix_fifo_drain_ctrl.sv
// Read-side sequencer for the paired FIX tag/value FIFOs. Pops one tag and one
// value together, presents them as a registered pair on a valid/ready port,
// counts fields and messages, and flags tag/value FIFO desynchronisation.
module fix_fifo_drain_ctrl #(
    parameter logic [31:0] EOM_TAG      = 32'h0000_3130,
    parameter int unsigned SYNC_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_empty_i,
    input  logic             v_empty_i,
    input  logic [31:0]      tag_i,
    input  logic [255:0]     value_i,
    output logic             t_rd_cs_o,
    output logic             t_rd_en_o,
    output logic             v_rd_cs_o,
    output logic             v_rd_en_o,
    output logic             pair_valid_o,
    input  logic             pair_ready_i,
    output logic [31:0]      pair_tag_o,
    output logic [255:0]     pair_value_o,
    output logic             pair_last_o,
    output logic [CNT_W-1:0] field_cnt_o,
    output logic [15:0]      msg_cnt_o,
    output logic             sync_err_o,
    input  logic             clr_err_i
);

    localparam int unsigned ToW = $clog2(SYNC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StCapture,
        StHold,
        StErr
    } state_e;

    state_e             r_state, w_state_d;
    logic [ToW-1:0]     r_to_cnt, w_to_cnt_d;
    logic               r_sync_err, w_sync_err_d;
    logic [CNT_W-1:0]   r_field_cnt, w_field_cnt_d;
    logic [15:0]        r_msg_cnt, w_msg_cnt_d;
    logic [31:0]        r_tag;
    logic [255:0]       r_value;
    logic               r_last;
    logic               w_both_avail;
    logic               w_flags_differ;

    assign w_both_avail   = !t_empty_i && !v_empty_i;
    assign w_flags_differ = t_empty_i != v_empty_i;

    // State, watchdog, error flag and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_to_cnt    <= '0;
            r_sync_err  <= 1'b0;
            r_field_cnt <= '0;
            r_msg_cnt   <= '0;
        end else begin
            r_state     <= w_state_d;
            r_to_cnt    <= w_to_cnt_d;
            r_sync_err  <= w_sync_err_d;
            r_field_cnt <= w_field_cnt_d;
            r_msg_cnt   <= w_msg_cnt_d;
        end
    end

    // Next-state logic; the watchdog only runs in IDLE and restarts elsewhere
    always_comb begin
        w_state_d     = r_state;
        w_to_cnt_d    = '0;
        w_sync_err_d  = r_sync_err;
        w_field_cnt_d = r_field_cnt;
        w_msg_cnt_d   = r_msg_cnt;
        if (clr_err_i) begin
            // Drops any pair in flight without counting it; message count survives
            w_state_d     = StIdle;
            w_sync_err_d  = 1'b0;
            w_field_cnt_d = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_flags_differ) begin
                        if (r_to_cnt == ToW'(SYNC_TIMEOUT - 1)) begin
                            w_sync_err_d = 1'b1;
                            w_state_d    = StErr;
                        end else begin
                            w_to_cnt_d = r_to_cnt + 1'b1;
                        end
                    end else if (w_both_avail && !r_sync_err) begin
                        w_state_d = StPop;
                    end
                end
                StPop:     w_state_d = StCapture;
                StCapture: w_state_d = StHold;
                StHold: begin
                    if (pair_ready_i) begin
                        if (r_last) begin
                            w_field_cnt_d = '0;
                            w_msg_cnt_d   = r_msg_cnt + 16'd1;
                        end else if (r_field_cnt != '1) begin
                            w_field_cnt_d = r_field_cnt + 1'b1;
                        end
                        w_state_d = w_both_avail ? StPop : StIdle;
                    end
                end
                StErr:   w_state_d = StErr;
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Pair data register, loaded one cycle after the pop when FIFO data is valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag   <= '0;
            r_value <= '0;
            r_last  <= 1'b0;
        end else if (r_state == StCapture) begin
            r_tag   <= tag_i;
            r_value <= value_i;
            r_last  <= (tag_i == EOM_TAG);
        end
    end

    // Both FIFOs are always read together, only in POP
    always_comb begin
        t_rd_cs_o    = (r_state == StPop);
        t_rd_en_o    = (r_state == StPop);
        v_rd_cs_o    = (r_state == StPop);
        v_rd_en_o    = (r_state == StPop);
        pair_valid_o = (r_state == StHold);
        pair_tag_o   = r_tag;
        pair_value_o = r_value;
        pair_last_o  = r_last;
        field_cnt_o  = r_field_cnt;
        msg_cnt_o    = r_msg_cnt;
        sync_err_o   = r_sync_err;
    end

endmodule

// File: tb/tb_fix_fifo_drain_ctrl.sv
// Scoreboard bench for fix_fifo_drain_ctrl: FIFO models feed the DUT, pushed
// tag/value pairs become expected pairs, a negedge monitor checks deliveries
// and the field/message counts against a simple message-level model.
module tb_fix_fifo_drain_ctrl;

    localparam logic [31:0] EOM = 32'h0000_3130;

    typedef struct packed {
        logic [31:0]  tag;
        logic [255:0] value;
    } pair_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         t_empty_i = 1'b1, v_empty_i = 1'b1;
    logic [31:0]  tag_i = '0;
    logic [255:0] value_i = '0;
    logic         t_rd_cs_o, t_rd_en_o, v_rd_cs_o, v_rd_en_o;
    logic         pair_valid_o;
    logic         pair_ready_i = 1'b0;
    logic [31:0]  pair_tag_o;
    logic [255:0] pair_value_o;
    logic         pair_last_o;
    logic [7:0]   field_cnt_o;
    logic [15:0]  msg_cnt_o;
    logic         sync_err_o;
    logic         clr_err_i = 1'b0;

    fix_fifo_drain_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .t_empty_i   (t_empty_i),
        .v_empty_i   (v_empty_i),
        .tag_i       (tag_i),
        .value_i     (value_i),
        .t_rd_cs_o   (t_rd_cs_o),
        .t_rd_en_o   (t_rd_en_o),
        .v_rd_cs_o   (v_rd_cs_o),
        .v_rd_en_o   (v_rd_en_o),
        .pair_valid_o(pair_valid_o),
        .pair_ready_i(pair_ready_i),
        .pair_tag_o  (pair_tag_o),
        .pair_value_o(pair_value_o),
        .pair_last_o (pair_last_o),
        .field_cnt_o (field_cnt_o),
        .msg_cnt_o   (msg_cnt_o),
        .sync_err_o  (sync_err_o),
        .clr_err_i   (clr_err_i)
    );

    always #5 clk = ~clk;

    logic [31:0]  tq[$];
    logic [255:0] vq[$];
    logic [31:0]  pend_t[$];
    logic [255:0] pend_v[$];
    pair_t        exp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          n_eom = 0;
    int          mdl_field = 0;
    logic [15:0] msg_base = '0;

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic upd_flags();
        t_empty_i = (tq.size() == 0);
        v_empty_i = (vq.size() == 0);
    endtask

    // A pair is expected once both its tag and its value have been pushed
    task automatic match_pairs();
        pair_t p;
        while (pend_t.size() > 0 && pend_v.size() > 0) begin
            p.tag   = pend_t.pop_front();
            p.value = pend_v.pop_front();
            exp_q.push_back(p);
        end
    endtask

    task automatic push_tag(input logic [31:0] t);
        tq.push_back(t);
        pend_t.push_back(t);
        match_pairs();
        upd_flags();
    endtask

    task automatic push_val(input logic [255:0] v);
        vq.push_back(v);
        pend_v.push_back(v);
        match_pairs();
        upd_flags();
    endtask

    task automatic push_pair(input logic [31:0] t, input logic [255:0] v);
        push_tag(t);
        push_val(v);
    endtask

    // One clock: sample read strobes mid-cycle, then apply the FIFO pop after the edge
    task automatic cycle();
        logic pop_now;
        @(negedge clk);
        pop_now = t_rd_en_o;
        chk("rd_strobes_together", {t_rd_cs_o, v_rd_cs_o, v_rd_en_o}, {3{t_rd_en_o}});
        @(posedge clk);
        #1;
        if (pop_now) begin
            pops++;
            if (tq.size() == 0 || vq.size() == 0) begin
                chk("pop_nonempty", 1'b0, 1'b1);
            end else begin
                tag_i   = tq.pop_front();
                value_i = vq.pop_front();
            end
        end
        upd_flags();
    endtask

    task automatic wait_drain(input int bound);
        pair_ready_i = 1'b1;
        for (int i = 0; i < bound; i++) begin
            if (exp_q.size() == 0 && !pair_valid_o) break;
            cycle();
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (pair_valid_o) break;
            cycle();
        end
        chk("valid_seen", pair_valid_o, 1'b1);
    endtask

    // Monitor: counts and delivered pairs against the message-level model
    logic         prev_hold = 1'b0;
    logic [31:0]  prev_tag;
    logic [255:0] prev_val;
    always @(negedge clk) begin
        pair_t e;
        if (!rst) begin
            mdl_field = 0;
            n_eom     = 0;
            prev_hold = 1'b0;
        end else begin
            chk("field_cnt", field_cnt_o, mdl_field);
            chk("msg_cnt", msg_cnt_o, 16'(msg_base + 16'(n_eom)));
            if (prev_hold && pair_valid_o)
                chk("hold_stable", {pair_tag_o, pair_value_o}, {prev_tag, prev_val});
            if (pair_valid_o && pair_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pair", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair_tag", pair_tag_o, e.tag);
                    chk("pair_value", pair_value_o, e.value);
                    chk("pair_last", pair_last_o, e.tag == EOM);
                    if (e.tag == EOM) begin
                        n_eom++;
                        mdl_field = 0;
                    end else if (mdl_field < 255) begin
                        mdl_field++;
                    end
                end
            end
            if (clr_err_i) mdl_field = 0;
            prev_hold = pair_valid_o && !pair_ready_i;
            prev_tag  = pair_tag_o;
            prev_val  = pair_value_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        logic [15:0] m0;

        // Reset state
        #1;
        chk("rst_valid", pair_valid_o, 1'b0);
        chk("rst_rd", {t_rd_cs_o, t_rd_en_o, v_rd_cs_o, v_rd_en_o}, 4'b0);
        chk("rst_counts", {field_cnt_o, msg_cnt_o}, 24'h0);
        chk("rst_err_last", {sync_err_o, pair_last_o}, 2'b0);
        chk("rst_tag", pair_tag_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single pair and 3-cycle latency
        pair_ready_i = 1'b1;
        p0 = pops;
        push_pair(32'h0000_3335, 256'h41);
        cycle();
        cycle();
        chk("latency_not_yet", pair_valid_o, 1'b0);
        cycle();
        chk("latency_3", pair_valid_o, 1'b1);
        chk("single_last", pair_last_o, 1'b0);
        wait_drain(20);
        chk("single_pop_count", pops - p0, 1);
        chk("single_field", field_cnt_o, 8'd1);

        // Message end on tag 10
        m0 = msg_cnt_o;
        push_pair(32'd8,  256'h100);
        push_pair(32'd9,  256'h101);
        push_pair(32'd35, 256'h102);
        push_pair(EOM,    256'h103);
        wait_drain(60);
        chk("msg_end_field", field_cnt_o, 8'd0);
        chk("msg_end_msg", msg_cnt_o, m0 + 16'd1);

        // Backpressure
        pair_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) push_pair(32'h0000_3400 + i, 256'h200 + i);
        wait_valid(10);
        p0 = pops;
        repeat (10) cycle();
        chk("bp_no_pop", pops - p0, 0);
        chk("bp_still_valid", pair_valid_o, 1'b1);
        pair_ready_i = 1'b1;
        cycle();
        chk("bp_pop_next", t_rd_en_o, 1'b1);
        wait_drain(30);

        // Desync watchdog
        p0 = pops;
        push_tag(32'h0000_3532);
        repeat (15) cycle();
        chk("desync_15", sync_err_o, 1'b0);
        cycle();
        chk("desync_16", sync_err_o, 1'b1);
        repeat (3) cycle();
        chk("desync_no_pop", pops - p0, 0);
        chk("desync_no_valid", pair_valid_o, 1'b0);
        clr_err_i = 1'b1;
        cycle();
        clr_err_i = 1'b0;
        chk("clr_err", sync_err_o, 1'b0);
        push_val(256'hABC);
        wait_drain(30);
        chk("after_clr_pops", pops - p0, 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (tq.size() < 3 && $urandom_range(0, 1) == 1)
                push_pair(($urandom_range(0, 3) == 0) ? EOM : 32'($urandom),
                          {8{32'($urandom)}});
            pair_ready_i = ($urandom_range(0, 3) != 0);
            cycle();
        end
        wait_drain(100);

        // Message counter wrap
        force dut.r_msg_cnt = 16'hFFFF;
        msg_base = 16'hFFFF - 16'(n_eom);
        cycle();
        release dut.r_msg_cnt;
        cycle();
        chk("wrap_preset", msg_cnt_o, 16'hFFFF);
        push_pair(EOM, 256'h5);
        wait_drain(20);
        chk("wrap_zero", msg_cnt_o, 16'h0);

        // Asynchronous reset while holding a pair
        push_pair(EOM, 256'h6);
        push_pair(32'h0000_3338, 256'h7);
        wait_drain(30);
        pair_ready_i = 1'b0;
        push_pair(32'h0000_3336, 256'h77);
        wait_valid(10);
        chk("pre_rst_counts", {field_cnt_o, msg_cnt_o}, {8'd1, 16'd1});
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", pair_valid_o, 1'b0);
        chk("arst_rd", {t_rd_cs_o, t_rd_en_o, v_rd_cs_o, v_rd_en_o}, 4'b0);
        chk("arst_counts", {field_cnt_o, msg_cnt_o}, 24'h0);
        tq.delete();
        vq.delete();
        pend_t.delete();
        pend_v.delete();
        exp_q.delete();
        upd_flags();
        msg_base = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        pair_ready_i = 1'b1;
        push_pair(32'h0000_3337, 256'h88);
        wait_drain(20);
        chk("post_rst_field", field_cnt_o, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fix_fifo_drain_ctrl.md
Name: fix_fifo_drain_ctrl

Overview:
- Read-side sequencer for the paired tag FIFO (32-bit) and value FIFO (256-bit) fed by the FIX parser output stage.
- Pops one tag and one value in lockstep and presents them as a single tag/value pair on a valid/ready interface to the downstream message consumer.
- Flags message end on the CheckSum tag, counts fields and messages, and detects tag/value FIFO desynchronisation with a timeout.

Parameters:
- EOM_TAG, 32'h0000_3130, tag value marking the last field of a message (ASCII "10", right-justified).
- SYNC_TIMEOUT, 16, cycles one FIFO may stay non-empty while the other is empty before sync_err_o is raised.
- CNT_W, 8, width of the per-message field counter.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- t_empty_i  in  1  tag FIFO empty.
- v_empty_i  in  1  value FIFO empty.
- tag_i  in  32  tag FIFO read data, valid 1 cycle after pop.
- value_i  in  256  value FIFO read data, valid 1 cycle after pop.
- t_rd_cs_o  out  1  tag FIFO read chip select.
- t_rd_en_o  out  1  tag FIFO read enable.
- v_rd_cs_o  out  1  value FIFO read chip select.
- v_rd_en_o  out  1  value FIFO read enable.
- pair_valid_o  out  1  output pair valid.
- pair_ready_i  in  1  consumer accepts pair.
- pair_tag_o  out  32  registered tag.
- pair_value_o  out  256  registered value.
- pair_last_o  out  1  pair is the last field of its message (tag == EOM_TAG).
- field_cnt_o  out  CNT_W  fields accepted in the current message.
- msg_cnt_o  out  16  completed messages, wraps.
- sync_err_o  out  1  sticky desynchronisation error.
- clr_err_i  in  1  clears sync_err_o and returns the block to IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; timeout counter 0.
- FSM states: IDLE, POP, CAPTURE, HOLD, ERR.
- IDLE -> POP when !t_empty_i && !v_empty_i && !sync_err.
- POP (1 cycle): t_rd_cs_o, t_rd_en_o, v_rd_cs_o and v_rd_en_o all 1. Both FIFOs are always popped in the same cycle; a single-sided pop is never issued. Next state CAPTURE.
- CAPTURE: register tag_i and value_i into pair_tag_o and pair_value_o; set pair_last_o = (tag_i == EOM_TAG); assert pair_valid_o the next cycle; next state HOLD.
- Latency: 3 cycles from both FIFOs non-empty in IDLE to pair_valid_o = 1.
- HOLD: pair_valid_o held at 1 and data held stable until pair_valid_o && pair_ready_i.
- On accept in HOLD:
  - If !pair_last_o: field_cnt_o += 1 (saturates at all-ones).
  - If pair_last_o: field_cnt_o <= 0 and msg_cnt_o += 1 (wraps at 16'hFFFF -> 0).
  - pair_valid_o drops the next cycle.
  - Next state is POP directly if both FIFOs are non-empty; otherwise IDLE. Back-to-back throughput is 1 pair per 3 cycles.
- pair_ready_i asserted when pair_valid_o = 0 has no effect.
- Sync watchdog (IDLE only):
  - Counts consecutive cycles with t_empty_i != v_empty_i.
  - Counter resets when the two empty flags are equal, or when the state is not IDLE.
  - When the count reaches SYNC_TIMEOUT: sync_err_o <= 1 and state ERR.
- ERR: no reads issued; pair_valid_o = 0; counters frozen.
- clr_err_i = 1 (any state): sync_err_o <= 0, timeout counter <= 0, field_cnt_o <= 0, state IDLE. msg_cnt_o is preserved.
  - If clr_err_i arrives in HOLD, the pending pair is dropped without counting.
- Reset mid-operation: immediate return to the reset state; a pop in flight is lost, and no recovery of FIFO contents is attempted.
- Read chip selects and read enables are never asserted outside POP.

Test Plan:
- Single pair: preload tag 32'h0000_3335, value 256'h41, hold pair_ready_i=1 -> pair_valid_o rises 3 cycles after release; rd_en pulses exactly once; field_cnt_o=1; pair_last_o=0.
- Message end: push tags 8, 9, 35, 10 with four values -> 4 pairs in order; pair_last_o set only on the 4th; afterwards field_cnt_o=0 and msg_cnt_o=1.
- Backpressure: pair_ready_i=0 for 10 cycles with FIFOs full -> pair data stable, no further rd_en; on release, next POP occurs the cycle after accept.
- Desync: push 1 tag and 0 values -> sync_err_o=1 after 16 cycles, no rd_en ever issued; pulse clr_err_i then push a value -> normal pair delivered.
- Counter wrap: preset msg_cnt_o to 16'hFFFF via 65535 messages (or force), send one more EOM pair -> msg_cnt_o=0.
- Reset during HOLD: drive rst=0 asynchronously mid-cycle -> pair_valid_o, all rd_en/rd_cs, and counters go to 0 immediately without waiting for a clock edge.
